game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter V_ACTIVE, default 480, number of visible lines; vblank starts at vpos == V_ACTIVE.
REQ-002 Parameter TICK_DIV, default 3, number of 60 Hz ticks per 20 Hz tick; legal range 2..15.
REQ-003 clk  input  1  pixel clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 i_hpos  input  10  current horizontal pixel position from the VGA timing generator.
REQ-006 i_vpos  input  10  current vertical line position from the VGA timing generator.
REQ-007 i_button  input  1  debounced start/jump button level.
REQ-008 i_crash  input  1  collision flag from rendering; level, any cycle.
REQ-009 o_tick_60hz  output  1  one-cycle frame tick.
REQ-010 o_tick_20hz  output  2  two consecutive one-cycle pulses: bit [0], then bit [1].
REQ-011 o_debounce_en  output  1  one-cycle pulse on each rising edge of i_vpos[4].
REQ-012 o_state  output  2  game state: 00 IDLE, 01 RUN, 10 OVER.
REQ-013 o_run_en  output  1  high while o_state == RUN.
REQ-014 o_game_over_pulse  output  1  one-cycle pulse on the RUN->OVER transition.
REQ-015 o_score  output  16  four BCD digits, thousands digit in the MSBs.
REQ-016 o_speed  output  2  obstacle speed level.

Function
REQ-017 o_tick_60hz SHALL assert for exactly one cycle, one cycle after the clock edge that samples i_hpos == 0 and i_vpos == V_ACTIVE.
REQ-018 A frame counter (0..TICK_DIV-1) SHALL increment on each o_tick_60hz and wrap to 0.
REQ-019 When the frame counter wraps, o_tick_20hz[0] SHALL assert the cycle after o_tick_60hz, and o_tick_20hz[1] SHALL assert the cycle after that.
REQ-020 At most one bit of o_tick_20hz SHALL be high in any cycle.
REQ-021 o_debounce_en SHALL assert for one cycle, one cycle after i_vpos[4] is sampled 1 following a sample of 0.
REQ-022 Button edge: the block SHALL register i_button; a press is a sample of 1 following a sample of 0.
REQ-023 IDLE->RUN on a press; score SHALL clear to 0000 in the same cycle.
REQ-024 RUN->OVER when i_crash is sampled 1; o_game_over_pulse SHALL be high for exactly that one transition cycle.
REQ-025 OVER->RUN on a press; score SHALL clear to 0000 in the same cycle.
REQ-026 In RUN, if a press and i_crash occur in the same cycle, the crash SHALL win and the next state SHALL be OVER.
REQ-027 i_crash SHALL be ignored in IDLE and OVER; state 11 is illegal and SHALL recover to IDLE on the next cycle.
REQ-028 In RUN, score SHALL increment by 1 (BCD) on each o_tick_20hz[0]; each digit rolls 9->0 with a carry.
REQ-029 Score SHALL saturate at 9999.
REQ-030 Score SHALL hold in IDLE and OVER.
REQ-031 o_run_en SHALL be combinationally equal to (o_state == 01); all other outputs SHALL be registered.

Reset
REQ-032 While rst is high, all outputs SHALL be 0: o_state = IDLE, o_score = 0000, o_speed = 0, and no tick outputs.
REQ-033 While rst is high, the frame counter, button register and vpos[4] history SHALL be 0.
REQ-034 Asserting rst mid-game SHALL abandon RUN immediately; no o_game_over_pulse SHALL be produced.
REQ-035 After rst deasserts, the first o_tick_60hz SHALL wait for the next sample of hpos == 0 and vpos == V_ACTIVE.

Configuration
REQ-036 With macro GAME_SEQUENCER_SPEEDUP_EN defined, o_speed SHALL be derived from the score, registered and updated with it: 0 if score < 100, 1 if < 300, 2 if < 600, 3 otherwise.
REQ-037 Without GAME_SEQUENCER_SPEEDUP_EN, o_speed SHALL be constant 0 and no comparison logic SHALL be synthesised.

Verification
REQ-038 Drive the VGA counters through 6 frames with TICK_DIV=3 -> 6 o_tick_60hz pulses at vpos 480 / hpos 0; o_tick_20hz[0] on the 3rd and 6th tick (+1 cycle); [1] on the next cycle.
REQ-039 Sweep vpos 0..63 -> o_debounce_en pulses exactly at vpos 16 and 48, one cycle late.
REQ-040 Press in IDLE, crash at score 0042 -> o_state 01 then 10; single o_game_over_pulse; o_score holds 0042; a later press clears to 0000 and returns to RUN.
REQ-041 Press and i_crash in the same cycle in RUN -> o_state 10, game-over pulse asserted, score unchanged.
REQ-042 Preload the score to 0099/0299/9998 via ticks, with SPEEDUP_EN -> o_speed 0->1 at 0100, 1->2 at 0300, and the score saturates at 9999; without the macro o_speed stays 0.
REQ-043 Assert rst asynchronously mid-RUN at score 0123 -> all outputs 0 immediately, no game-over pulse, o_state 00.

Source files
------------

// File: rtl/game_sequencer.sv
// game_sequencer: frame/20 Hz tick generation, vpos[4] debounce strobe and
// the IDLE/RUN/OVER game state machine with a saturating 4-digit BCD score.
// Optional feature: define GAME_SEQUENCER_SPEEDUP_EN to derive o_speed from
// the score; otherwise o_speed is tied to 0.
//
// state | meaning
// IDLE  | waiting for the first button press, score held
// RUN   | game active, score counts on each 20 Hz tick
// OVER  | crash seen, score frozen until the next press
// 11    | unused encoding, returns to IDLE
module game_sequencer #(
    parameter int V_ACTIVE = 480,
    parameter int TICK_DIV = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  i_hpos,
    input  logic [9:0]  i_vpos,
    input  logic        i_button,
    input  logic        i_crash,
    output logic        o_tick_60hz,
    output logic [1:0]  o_tick_20hz,
    output logic        o_debounce_en,
    output logic [1:0]  o_state,
    output logic        o_run_en,
    output logic        o_game_over_pulse,
    output logic [15:0] o_score,
    output logic [1:0]  o_speed
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        OVER    = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [3:0] FRAME_LAST = 4'(TICK_DIV - 1);

    logic        tick60_q, tick60_d;
    logic [1:0]  tick20_q, tick20_d;
    logic [3:0]  frame_q, frame_d;
    logic        vpos4_q, vpos4_d;
    logic        deb_q, deb_d;
    logic        btn_q, btn_d;
    state_t      state_q, state_d;
    logic        over_pulse_q, over_pulse_d;
    logic [15:0] score_q, score_d;
    logic        press;

    // Saturating BCD increment; each digit rolls 9->0 and carries left.
    function automatic logic [15:0] bcd_inc(input logic [15:0] s);
        logic [15:0] r;
        logic        carry;
        r     = s;
        carry = 1'b1;
        if (s != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // Frame tick, 20 Hz two-phase pulse, vpos[4] edge strobe and button history.
    always_comb begin
        tick60_d = (i_hpos == 10'd0) && (i_vpos == V_ACT);
        frame_d  = frame_q;
        tick20_d = {tick20_q[0], 1'b0};
        if (tick60_q) begin
            if (frame_q == FRAME_LAST) begin
                frame_d     = 4'd0;
                tick20_d[0] = 1'b1;
            end else begin
                frame_d = frame_q + 4'd1;
            end
        end
        vpos4_d = i_vpos[4];
        deb_d   = i_vpos[4] & ~vpos4_q;
        btn_d   = i_button;
    end

    assign press = i_button & ~btn_q;

    // Game state next-state, score update and game-over strobe; crash beats press in RUN.
    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        over_pulse_d = 1'b0;
        case (state_q)
            IDLE, OVER: begin
                if (press) begin
                    state_d = RUN;
                    score_d = 16'h0000;
                end
            end
            RUN: begin
                if (i_crash) begin
                    state_d      = OVER;
                    over_pulse_d = 1'b1;
                end else if (tick20_q[0]) begin
                    score_d = bcd_inc(score_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and timing registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick60_q     <= 1'b0;
            tick20_q     <= 2'b00;
            frame_q      <= 4'd0;
            vpos4_q      <= 1'b0;
            deb_q        <= 1'b0;
            btn_q        <= 1'b0;
            state_q      <= IDLE;
            over_pulse_q <= 1'b0;
            score_q      <= 16'h0000;
        end else begin
            tick60_q     <= tick60_d;
            tick20_q     <= tick20_d;
            frame_q      <= frame_d;
            vpos4_q      <= vpos4_d;
            deb_q        <= deb_d;
            btn_q        <= btn_d;
            state_q      <= state_d;
            over_pulse_q <= over_pulse_d;
            score_q      <= score_d;
        end
    end

`ifdef GAME_SEQUENCER_SPEEDUP_EN
    logic [1:0] speed_q, speed_d;

    // Speed level follows the next score so it updates in the same cycle as the score.
    always_comb begin
        speed_d = 2'd3;
        if (score_d[15:12] == 4'd0) begin
            if (score_d[11:8] < 4'd1) begin
                speed_d = 2'd0;
            end else if (score_d[11:8] < 4'd3) begin
                speed_d = 2'd1;
            end else if (score_d[11:8] < 4'd6) begin
                speed_d = 2'd2;
            end
        end
    end

    // Speed register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed_q <= 2'd0;
        end else begin
            speed_q <= speed_d;
        end
    end

    assign o_speed = speed_q;
`else
    assign o_speed = 2'd0;
`endif

    assign o_tick_60hz       = tick60_q;
    assign o_tick_20hz       = tick20_q;
    assign o_debounce_en     = deb_q;
    assign o_state           = state_q;
    assign o_run_en          = (state_q == RUN);
    assign o_game_over_pulse = over_pulse_q;
    assign o_score           = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Testbench for game_sequencer: scenario tasks compared against an integer
// behavioural model of the game rules, plus fixed expectations per scenario.
module tb_game_sequencer;

    localparam int V_ACTIVE = 480;
    localparam int TICK_DIV = 3;
    localparam int H_TOTAL  = 4;
    localparam int V_TOTAL  = 485;
`ifdef GAME_SEQUENCER_SPEEDUP_EN
    localparam logic [1:0] SPD1 = 2'd1, SPD2 = 2'd2, SPD3 = 2'd3;
`else
    localparam logic [1:0] SPD1 = 2'd0, SPD2 = 2'd0, SPD3 = 2'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  hpos, vpos;
    logic        button, crash;
    logic        o_tick_60hz, o_debounce_en, o_run_en, o_game_over_pulse;
    logic [1:0]  o_tick_20hz, o_state, o_speed;
    logic [15:0] o_score;

    int checks   = 0;
    int failures = 0;

    game_sequencer #(.V_ACTIVE(V_ACTIVE), .TICK_DIV(TICK_DIV)) dut (
        .clk(clk), .rst(rst), .i_hpos(hpos), .i_vpos(vpos),
        .i_button(button), .i_crash(crash),
        .o_tick_60hz(o_tick_60hz), .o_tick_20hz(o_tick_20hz),
        .o_debounce_en(o_debounce_en), .o_state(o_state), .o_run_en(o_run_en),
        .o_game_over_pulse(o_game_over_pulse), .o_score(o_score), .o_speed(o_speed)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic       m_tick60, m_deb, m_pulse, m_btn_prev, m_v4_prev, m_press;
    logic [1:0] m_tick20;
    int         m_state, m_score, m_speed, m_ticks;

    function automatic logic [15:0] to_bcd(input int s);
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic int speed_of(input int s);
`ifdef GAME_SEQUENCER_SPEEDUP_EN
        if (s < 100) return 0;
        if (s < 300) return 1;
        if (s < 600) return 2;
        return 3;
`else
        return 0 * s;
`endif
    endfunction

    function automatic int score_next(input int st, input logic cr, input logic t,
                                      input logic pr, input int s);
        if (st == 1) return (!cr && t) ? ((s < 9999) ? s + 1 : 9999) : s;
        return pr ? 0 : s;
    endfunction

    assign m_press = button & ~m_btn_prev;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tick60 <= 0; m_tick20 <= 0; m_deb <= 0; m_pulse <= 0;
            m_btn_prev <= 0; m_v4_prev <= 0;
            m_state <= 0; m_score <= 0; m_speed <= 0; m_ticks <= 0;
        end else begin
            m_btn_prev <= button;
            m_v4_prev  <= vpos[4];
            m_tick60   <= (hpos == 0 && vpos == 10'(V_ACTIVE));
            m_deb      <= vpos[4] && !m_v4_prev;
            if (m_tick60) m_ticks <= m_ticks + 1;
            m_tick20   <= {m_tick20[0], (m_tick60 && ((m_ticks + 1) % TICK_DIV == 0))};
            m_pulse    <= (m_state == 1) && crash;
            if (m_state == 1) begin
                if (crash) m_state <= 2;
            end else if (m_press) begin
                m_state <= 1;
            end
            m_score <= score_next(m_state, crash, m_tick20[0], m_press, m_score);
            m_speed <= speed_of(score_next(m_state, crash, m_tick20[0], m_press, m_score));
        end
    end

    logic [25:0] dut_vec, exp_vec;
    assign dut_vec = {o_tick_60hz, o_tick_20hz, o_debounce_en, o_state, o_run_en,
                      o_game_over_pulse, o_score, o_speed};
    assign exp_vec = {m_tick60, m_tick20, m_deb, 2'(m_state), (m_state == 1),
                      m_pulse, to_bcd(m_score), 2'(m_speed)};

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            hpos = 10'($urandom_range(0, 3)); vpos = (i == 0) ? 10'(V_ACTIVE) : 10'($urandom_range(0, 63));
            button = 1'($urandom); crash = 1'($urandom);
            @(negedge clk);
            checks++;
            if (dut_vec !== 26'd0) begin
                failures++; $display("FAIL reset_outputs got=%h expected=0", dut_vec);
            end
        end
        hpos = 10'd1; vpos = 10'd0; button = 1'b0; crash = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_state !== 2'b00 || o_tick_60hz !== 1'b0) begin
            failures++; $display("FAIL reset_release state=%b tick=%b expected 00/0", o_state, o_tick_60hz);
        end
    endtask

    task automatic test_frame_ticks();
        int cyc = 0, pos_err = 0, hot_err = 0;
        int t60[$], t20a[$], t20b[$];
        for (int f = 0; f < 6; f++)
            for (int v = 0; v < V_TOTAL; v++)
                for (int h = 0; h < H_TOTAL; h++) begin
                    hpos = 10'(h); vpos = 10'(v);
                    @(negedge clk);
                    cyc++;
                    checks++;
                    if (dut_vec !== exp_vec) begin
                        failures++; $display("FAIL frame_model t=%0t got=%h expected=%h", $time, dut_vec, exp_vec);
                    end
                    if (o_tick_60hz) begin
                        t60.push_back(cyc);
                        if (!(hpos == 0 && vpos == 10'(V_ACTIVE))) pos_err++;
                    end
                    if (o_tick_20hz[0]) t20a.push_back(cyc);
                    if (o_tick_20hz[1]) t20b.push_back(cyc);
                    if (o_tick_20hz == 2'b11) hot_err++;
                end
        checks++;
        if (t60.size() != 6 || pos_err != 0) begin
            failures++; $display("FAIL frame_tick60 count=%0d poserr=%0d expected 6/0", t60.size(), pos_err);
        end
        checks++;
        if (t60.size() != 6 || t20a.size() != 2 || t20b.size() != 2) begin
            failures++; $display("FAIL frame_tick20_count a=%0d b=%0d expected 2/2", t20a.size(), t20b.size());
        end else begin
            checks++;
            if (t20a[0] != t60[2] + 1 || t20a[1] != t60[5] + 1 ||
                t20b[0] != t20a[0] + 1 || t20b[1] != t20a[1] + 1) begin
                failures++; $display("FAIL frame_tick20_pos a=%0d,%0d b=%0d,%0d t60=%0d,%0d",
                                     t20a[0], t20a[1], t20b[0], t20b[1], t60[2], t60[5]);
            end
        end
        checks++;
        if (hot_err != 0) begin
            failures++; $display("FAIL frame_tick20_onehot cycles=%0d expected 0", hot_err);
        end
    endtask

    task automatic test_debounce();
        int seen_v[$], seen_h[$];
        for (int v = 0; v < 64; v++)
            for (int h = 0; h < H_TOTAL; h++) begin
                hpos = 10'(h); vpos = 10'(v);
                @(negedge clk);
                checks++;
                if (dut_vec !== exp_vec) begin
                    failures++; $display("FAIL debounce_model t=%0t got=%h expected=%h", $time, dut_vec, exp_vec);
                end
                if (o_debounce_en) begin seen_v.push_back(int'(vpos)); seen_h.push_back(int'(hpos)); end
            end
        checks++;
        if (seen_v.size() != 2) begin
            failures++; $display("FAIL debounce_count got=%0d expected 2", seen_v.size());
        end else if (seen_v[0] != 16 || seen_v[1] != 48 || seen_h[0] != 0 || seen_h[1] != 0) begin
            failures++; $display("FAIL debounce_pos got=%0d/%0d,%0d/%0d expected 16/0,48/0",
                                 seen_v[0], seen_h[0], seen_v[1], seen_h[1]);
        end
    endtask

    task automatic test_game();
        int pulses = 0;
        bit hit = 0;
        hpos = 10'd1; vpos = 10'd0; button = 1'b0; crash = 1'b0;
        @(negedge clk);
        button = 1'b1;
        @(negedge clk);
        checks++;
        if (o_state !== 2'b01 || o_run_en !== 1'b1 || o_score !== 16'h0000) begin
            failures++; $display("FAIL game_start state=%b run=%b score=%h expected 01/1/0000", o_state, o_run_en, o_score);
        end
        button = 1'b0; hpos = 10'd0; vpos = 10'(V_ACTIVE);
        for (int i = 0; i < 1000 && !hit; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                failures++; $display("FAIL game_model t=%0t got=%h expected=%h", $time, dut_vec, exp_vec);
            end
            if (o_score === 16'h0042) hit = 1;
        end
        checks++;
        if (!hit) begin failures++; $display("FAIL game_reach42 score=%h expected 0042", o_score); end
        hpos = 10'd1; vpos = 10'd0; crash = 1'b1;
        @(negedge clk);
        checks++;
        if (o_state !== 2'b10 || o_game_over_pulse !== 1'b1 || o_score !== 16'h0042 || o_run_en !== 1'b0) begin
            failures++; $display("FAIL game_crash state=%b pulse=%b score=%h expected 10/1/0042",
                                 o_state, o_game_over_pulse, o_score);
        end
        for (int i = 0; i < 12; i++) begin
            crash = 1'($urandom); hpos = (i % 3 == 0) ? 10'd0 : 10'd2; vpos = 10'(V_ACTIVE);
            @(negedge clk);
            if (o_game_over_pulse) pulses++;
            checks++;
            if (o_state !== 2'b10 || o_score !== 16'h0042) begin
                failures++; $display("FAIL game_over_hold state=%b score=%h expected 10/0042", o_state, o_score);
            end
        end
        checks++;
        if (pulses != 0) begin failures++; $display("FAIL game_single_pulse extra=%0d expected 0", pulses); end
        crash = 1'b0; hpos = 10'd1; vpos = 10'd0; button = 1'b1;
        @(negedge clk);
        checks++;
        if (o_state !== 2'b01 || o_score !== 16'h0000) begin
            failures++; $display("FAIL game_restart state=%b score=%h expected 01/0000", o_state, o_score);
        end
        button = 1'b0;
    endtask

    task automatic test_press_crash();
        logic [15:0] hold;
        int k = int'($urandom_range(4, 15));
        hpos = 10'd0; vpos = 10'(V_ACTIVE);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                failures++; $display("FAIL presscrash_model t=%0t got=%h expected=%h", $time, dut_vec, exp_vec);
            end
        end
        hold = to_bcd(m_score);
        button = 1'b1; crash = 1'b1;
        @(negedge clk);
        checks++;
        if (o_state !== 2'b10 || o_game_over_pulse !== 1'b1 || o_score !== hold) begin
            failures++; $display("FAIL presscrash state=%b pulse=%b score=%h expected 10/1/%h",
                                 o_state, o_game_over_pulse, o_score, hold);
        end
        button = 1'b0; crash = 1'b0; hpos = 10'd1; vpos = 10'd0;
        @(negedge clk);
    endtask

    task automatic test_speed();
        logic [1:0] exp_s;
        bit hit = 0, known;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        button = 1'b1; @(negedge clk); button = 1'b0;
        hpos = 10'd0; vpos = 10'(V_ACTIVE);
        for (int i = 0; i < 32000 && !hit; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                failures++; $display("FAIL speed_model t=%0t got=%h expected=%h", $time, dut_vec, exp_vec);
            end
            known = 1; exp_s = 2'd0;
            case (o_score)
                16'h0099: exp_s = 2'd0;
                16'h0100, 16'h0299: exp_s = SPD1;
                16'h0300, 16'h0599: exp_s = SPD2;
                16'h0600, 16'h9998, 16'h9999: exp_s = SPD3;
                default: known = 0;
            endcase
            if (known) begin
                checks++;
                if (o_speed !== exp_s) begin
                    failures++; $display("FAIL speed_level score=%h got=%0d expected=%0d", o_score, o_speed, exp_s);
                end
            end
            if (o_score === 16'h9999) hit = 1;
        end
        checks++;
        if (!hit) begin failures++; $display("FAIL speed_reach9999 score=%h expected 9999", o_score); end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checks++;
            if (o_score !== 16'h9999 || o_speed !== SPD3) begin
                failures++; $display("FAIL speed_saturate score=%h speed=%0d expected 9999/%0d", o_score, o_speed, SPD3);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        bit hit = 0;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        button = 1'b1; hpos = 10'd1; vpos = 10'd0; @(negedge clk); button = 1'b0;
        hpos = 10'd0; vpos = 10'(V_ACTIVE);
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            if (o_score === 16'h0123) hit = 1;
        end
        checks++;
        if (!hit || o_state !== 2'b01) begin
            failures++; $display("FAIL midrun_reach score=%h state=%b expected 0123/01", o_score, o_state);
        end
        crash = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dut_vec !== 26'd0) begin failures++; $display("FAIL midrun_async got=%h expected=0", dut_vec); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== 26'd0) begin failures++; $display("FAIL midrun_hold got=%h expected=0", dut_vec); end
        end
        crash = 1'b0; rst = 1'b0; hpos = 10'd1; vpos = 10'd0;
        @(negedge clk);
        checks++;
        if (o_state !== 2'b00 || o_game_over_pulse !== 1'b0 || o_score !== 16'h0000) begin
            failures++; $display("FAIL midrun_after state=%b pulse=%b score=%h expected 00/0/0000",
                                 o_state, o_game_over_pulse, o_score);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            hpos   = ($urandom_range(0, 2) == 0) ? 10'd0 : 10'($urandom_range(0, 3));
            vpos   = ($urandom_range(0, 2) == 0) ? 10'(V_ACTIVE) : 10'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) button = ~button;
            crash  = ($urandom_range(0, 39) == 0);
            rst    = ($urandom_range(0, 499) == 0);
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                failures++; $display("FAIL random_model t=%0t got=%h expected=%h", $time, dut_vec, exp_vec);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; button = 1'b0; crash = 1'b0; hpos = 10'd1; vpos = 10'd0;
        @(negedge clk);
        test_reset();
        test_frame_ticks();
        test_debounce();
        test_game();
        test_press_crash();
        test_speed();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
